key_checker: RTL and testbench
==============================

KEY_CHECKER -- requirements
Module: key_checker

Interface
REQ-001 Parameters: WIDTH, default 8, key byte width.
REQ-002 Parameters: LEN, default 8, number of key words checked per run (1..255).
REQ-003 Parameters: SEED, default 8'hD9, first expected key word.
REQ-004 Reset: the block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: start  input  1  begin a check run; sampled only in IDLE.
REQ-008 Port: key_in  input  WIDTH  received key word.
REQ-009 Port: key_valid  input  1  key_in is valid this cycle.
REQ-010 Port: key_ready  output  1  checker accepts a word; high only in CHECK.
REQ-011 Port: busy  output  1  high in CHECK.
REQ-012 Port: done  output  1  one-cycle pulse when a run completes.
REQ-013 Port: pass  output  1  result of the last completed run; held until the next start.
REQ-014 Port: err_idx  output  8  index of the first mismatching word; 8'hFF if none.

Function
REQ-015 States SHALL be IDLE, CHECK and DONE; the reset state is IDLE.
REQ-016 In IDLE, start=1 SHALL load exp=SEED, cnt=0 (2-bit), idx=0 and fail=0, set err_idx=8'hFF and pass=0, and enter CHECK on the next edge.
REQ-017 A beat SHALL be accepted only when key_valid and key_ready are both high; key_valid low SHALL stall the run with no state change.
REQ-018 On each accepted beat, the block SHALL compare key_in==exp; on a mismatch it SHALL set fail, and if err_idx==8'hFF it SHALL set err_idx=idx.
REQ-019 On each accepted beat, the block SHALL update exp <= exp + 2*cnt modulo 2^WIDTH, then cnt <= cnt+1 (wraps 3->0), then idx <= idx+1.
REQ-020 The expected sequence for SEED=D9 SHALL be D9, D9, DB, DF, E5, E5, E7, EB, F1, ...; word 4n SHALL equal SEED+12n mod 256.
REQ-021 A mismatch SHALL NOT end the run early; all LEN words SHALL be consumed, so run length is independent of the data.
REQ-022 After the beat with idx==LEN-1 is accepted, the block SHALL enter DONE; key_ready SHALL be low from that point on.
REQ-023 In DONE, done SHALL be 1 and pass SHALL be updated to !fail; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-024 start SHALL be ignored in CHECK and in DONE.
REQ-025 Latency from the final accepted beat to the done pulse SHALL be 1 cycle.

Reset
REQ-026 While reset is low, the block SHALL be in IDLE with key_ready=0, busy=0, done=0, pass=0, err_idx=8'hFF, exp=SEED, cnt=0 and idx=0.
REQ-027 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL require a new start.

Structure
REQ-028 Package key_pkg SHALL hold the state enum, the KEY_SEED constant (8'hD9) and the default WIDTH and LEN.
REQ-029 Sub-module key_seq_gen SHALL hold exp and cnt, with inputs load and advance, and output exp; key_checker SHALL hold the FSM, idx, fail and the result outputs.

Verification
REQ-030 Start, then 8 back-to-back words D9,D9,DB,DF,E5,E5,E7,EB -> done pulse 1 cycle after the last beat, pass=1, err_idx=FF.
REQ-031 Same run with word 3 = DE and word 6 = 00 -> all 8 words still consumed, pass=0, err_idx=3.
REQ-032 Correct words with key_valid low for 3 cycles between each beat -> key_ready stays high, pass=1, done exactly once.
REQ-033 LEN=20, correct sequence -> word 16 = 09 (wrap) is accepted, pass=1.
REQ-034 Reset pulled low after 4 beats, released, then a full correct run -> no done during the aborted run, then pass=1.
REQ-035 start pulsed during CHECK and during DONE -> ignored, run result unchanged, block returns to IDLE.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the key checker: FSM states, the seed of the
// expected key sequence, and default word width and run length.
package key_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] KEY_SEED  = 8'hD9;
  localparam int         DEF_WIDTH = 8;
  localparam int         DEF_LEN   = 8;
  localparam logic [7:0] NO_ERR    = 8'hFF;

endpackage

// File: rtl/key_seq_gen.sv
// Expected-key generator: exp steps by 2*cnt per accepted word, cnt is a
// 2-bit counter, so every fourth word is SEED + 12n.
module key_seq_gen
  import key_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(KEY_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] exp
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp <= SEED;
      cnt <= 2'd0;
    end else if (load) begin
      exp <= SEED;
      cnt <= 2'd0;
    end else if (advance) begin
      exp <= exp + WIDTH'({cnt, 1'b0});
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/key_checker.sv
// Compares a stream of LEN key words against the generated sequence, records
// the first mismatching index and reports pass/fail with a one-cycle done pulse.
module key_checker
  import key_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               LEN   = DEF_LEN,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(KEY_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_idx
);

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_t           state;
  logic [7:0]       idx;
  logic             fail;
  logic [WIDTH-1:0] exp;
  logic             load;
  logic             accept;
  logic             mismatch;

  assign key_ready = (state == S_CHECK);
  assign busy      = (state == S_CHECK);
  assign load      = (state == S_IDLE) && start;
  assign accept    = key_ready && key_valid;
  assign mismatch  = (key_in != exp);

  key_seq_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (accept),
    .exp     (exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      idx     <= 8'd0;
      fail    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_idx <= NO_ERR;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx     <= 8'd0;
            fail    <= 1'b0;
            pass    <= 1'b0;
            err_idx <= NO_ERR;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (mismatch) begin
              fail <= 1'b1;
              if (err_idx == NO_ERR) err_idx <= idx;
            end
            idx <= idx + 8'd1;
            // Result becomes visible together with done, including the last beat.
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= !(fail || mismatch);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_checker.sv
// Self-checking bench for key_checker: directed scenarios plus random runs
// checked against an arithmetic model of the expected key sequence.
module tb_key_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       key_valid = 1'b0;

  logic       a_ready, a_busy, a_done, a_pass;
  logic [7:0] a_err;
  logic       b_ready, b_busy, b_done, b_pass;
  logic [7:0] b_err;

  int errors = 0;
  int checks = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  bit sel = 1'b0;

  int r_ready_low, r_stall_ready_low, r_done_early, r_done_after_last;

  always #5 clk = ~clk;

  key_checker #(.WIDTH(8), .LEN(8), .SEED(8'hD9)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in), .key_valid(key_valid),
    .key_ready(a_ready), .busy(a_busy), .done(a_done), .pass(a_pass), .err_idx(a_err)
  );

  key_checker #(.WIDTH(8), .LEN(20), .SEED(8'hD9)) dut20 (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in), .key_valid(key_valid),
    .key_ready(b_ready), .busy(b_busy), .done(b_done), .pass(b_pass), .err_idx(b_err)
  );

  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  // Word i of the expected sequence: seed plus the sum of 2*(j mod 4) for j < i.
  function automatic logic [7:0] model_word(input int i);
    int s;
    s = 'hD9;
    for (int j = 0; j < i; j++) s += 2 * (j % 4);
    return 8'(s % 256);
  endfunction

  function automatic logic [7:0] model_err(input logic [7:0] w[$]);
    foreach (w[i]) if (w[i] != model_word(i)) return 8'(i);
    return 8'hFF;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_ready();
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic cur_done();
    return sel ? b_done : a_done;
  endfunction

  task automatic good_words(input int n, output logic [7:0] w[$]);
    w = {};
    for (int i = 0; i < n; i++) w.push_back(model_word(i));
  endtask

  // Starts a run and presents every word once, with idle gaps before each beat.
  task automatic drive_run(input logic [7:0] w[$], input int gap, input bit rnd_gap);
    r_ready_low = 0;
    r_stall_ready_low = 0;
    r_done_early = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    foreach (w[i]) begin
      int g;
      g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
      key_valid = 1'b0;
      repeat (g) begin
        cycle();
        if (!cur_ready()) r_stall_ready_low++;
        if (cur_done()) r_done_early++;
      end
      key_in = w[i];
      key_valid = 1'b1;
      if (!cur_ready()) r_ready_low++;
      if (cur_done()) r_done_early++;
      cycle();
    end
    key_valid = 1'b0;
    r_done_after_last = int'(cur_done());
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) cycle();
    checks++;
    if ({a_ready, a_busy, a_done, a_pass} !== 4'b0000 || a_err !== 8'hFF) begin
      errors++;
      $display("FAIL reset_a: got ready/busy/done/pass=%b%b%b%b err=%h want 0000 ff",
               a_ready, a_busy, a_done, a_pass, a_err);
    end
    checks++;
    if ({b_ready, b_busy, b_done, b_pass} !== 4'b0000 || b_err !== 8'hFF) begin
      errors++;
      $display("FAIL reset_b: got ready/busy/done/pass=%b%b%b%b err=%h want 0000 ff",
               b_ready, b_busy, b_done, b_pass, b_err);
    end
    reset = 1'b1;
    cycle();
    $display("reset: outputs checked");
  endtask

  task automatic test_pass();
    logic [7:0] w[$];
    int dc;
    sel = 1'b0;
    good_words(8, w);
    dc = a_done_cnt;
    drive_run(w, 0, 1'b0);
    checks++;
    if (r_ready_low != 0 || r_done_after_last != 1 || r_done_early != 0) begin
      errors++;
      $display("FAIL pass_flow: ready_low=%0d done_last=%0d done_early=%0d want 0 1 0",
               r_ready_low, r_done_after_last, r_done_early);
    end
    checks++;
    if (a_pass !== 1'b1 || a_err !== 8'hFF) begin
      errors++;
      $display("FAIL pass_result: pass=%b err=%h want 1 ff", a_pass, a_err);
    end
    cycle();
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_done_cnt != dc + 1 || a_pass !== 1'b1) begin
      errors++;
      $display("FAIL pass_after: done=%b busy=%b pulses=%0d pass=%b want 0 0 1 1",
               a_done, a_busy, a_done_cnt - dc, a_pass);
    end
    $display("pass run: pass=%b err_idx=%h", a_pass, a_err);
  endtask

  task automatic test_mismatch();
    logic [7:0] w[$];
    sel = 1'b0;
    good_words(8, w);
    w[3] = 8'hDE;
    w[6] = 8'h00;
    drive_run(w, 0, 1'b0);
    checks++;
    if (r_ready_low != 0 || r_done_after_last != 1 || r_done_early != 0) begin
      errors++;
      $display("FAIL mismatch_flow: ready_low=%0d done_last=%0d done_early=%0d want 0 1 0",
               r_ready_low, r_done_after_last, r_done_early);
    end
    checks++;
    if (a_pass !== 1'b0 || a_err !== 8'h03) begin
      errors++;
      $display("FAIL mismatch_result: pass=%b err=%h want 0 03", a_pass, a_err);
    end
    cycle();
    $display("mismatch run: pass=%b err_idx=%h", a_pass, a_err);
  endtask

  task automatic test_stall();
    logic [7:0] w[$];
    int dc;
    sel = 1'b0;
    good_words(8, w);
    dc = a_done_cnt;
    drive_run(w, 3, 1'b0);
    cycle();
    checks++;
    if (r_stall_ready_low != 0 || r_done_early != 0 || r_done_after_last != 1) begin
      errors++;
      $display("FAIL stall_flow: stall_ready_low=%0d done_early=%0d done_last=%0d want 0 0 1",
               r_stall_ready_low, r_done_early, r_done_after_last);
    end
    checks++;
    if (a_pass !== 1'b1 || a_err !== 8'hFF || a_done_cnt != dc + 1) begin
      errors++;
      $display("FAIL stall_result: pass=%b err=%h pulses=%0d want 1 ff 1",
               a_pass, a_err, a_done_cnt - dc);
    end
    $display("stall run: pass=%b pulses=%0d", a_pass, a_done_cnt - dc);
  endtask

  task automatic test_len20();
    logic [7:0] w[$];
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    sel = 1'b1;
    good_words(20, w);
    drive_run(w, 0, 1'b0);
    checks++;
    if (r_ready_low != 0 || r_done_after_last != 1 || r_done_early != 0) begin
      errors++;
      $display("FAIL len20_flow: ready_low=%0d done_last=%0d done_early=%0d want 0 1 0",
               r_ready_low, r_done_after_last, r_done_early);
    end
    checks++;
    if (b_pass !== 1'b1 || b_err !== 8'hFF) begin
      errors++;
      $display("FAIL len20_result: pass=%b err=%h want 1 ff", b_pass, b_err);
    end
    cycle();
    sel = 1'b0;
    $display("len20 run: word16=%h pass=%b err_idx=%h", w[16], b_pass, b_err);
  endtask

  task automatic test_abort();
    logic [7:0] w[$];
    int dc;
    sel = 1'b0;
    good_words(8, w);
    dc = a_done_cnt;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_in = w[i];
      key_valid = 1'b1;
      cycle();
    end
    key_valid = 1'b0;
    reset = 1'b0;
    #2;
    checks++;
    if ({a_ready, a_busy, a_done, a_pass} !== 4'b0000 || a_err !== 8'hFF) begin
      errors++;
      $display("FAIL abort_reset: ready/busy/done/pass=%b%b%b%b err=%h want 0000 ff",
               a_ready, a_busy, a_done, a_pass, a_err);
    end
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_in = w[i];
      key_valid = 1'b1;
      cycle();
      checks++;
      if (a_busy !== 1'b0 || a_ready !== 1'b0) begin
        errors++;
        $display("FAIL abort_nostart: busy=%b ready=%b want 0 0", a_busy, a_ready);
      end
    end
    key_valid = 1'b0;
    checks++;
    if (a_done_cnt != dc) begin
      errors++;
      $display("FAIL abort_no_done: pulses=%0d want 0", a_done_cnt - dc);
    end
    drive_run(w, 0, 1'b0);
    checks++;
    if (r_done_after_last != 1 || a_pass !== 1'b1 || a_err !== 8'hFF) begin
      errors++;
      $display("FAIL abort_rerun: done=%0d pass=%b err=%h want 1 1 ff",
               r_done_after_last, a_pass, a_err);
    end
    cycle();
    $display("abort: rerun pass=%b", a_pass);
  endtask

  task automatic test_start_ignored();
    logic [7:0] w[$];
    int dc;
    sel = 1'b0;
    good_words(8, w);
    w[5] = ~w[5];
    dc = a_done_cnt;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        key_valid = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
      end
      key_in = w[i];
      key_valid = 1'b1;
      cycle();
    end
    key_valid = 1'b0;
    checks++;
    if (a_done !== 1'b1 || a_pass !== 1'b0 || a_err !== 8'h05) begin
      errors++;
      $display("FAIL start_in_check: done=%b pass=%b err=%h want 1 0 05", a_done, a_pass, a_err);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0 || a_err !== 8'h05
        || a_done_cnt != dc + 1) begin
      errors++;
      $display("FAIL start_in_done: busy=%b done=%b pass=%b err=%h pulses=%0d want 0 0 0 05 1",
               a_busy, a_done, a_pass, a_err, a_done_cnt - dc);
    end
    $display("start ignored: err_idx=%h busy=%b", a_err, a_busy);
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int r = 0; r < 8; r++) begin
      logic [7:0] w[$];
      logic [7:0] want_err;
      logic       want_pass;
      w = {};
      for (int i = 0; i < 8; i++)
        w.push_back(($urandom_range(0, 3) != 0) ? model_word(i) : 8'($urandom));
      want_err  = model_err(w);
      want_pass = (want_err == 8'hFF);
      drive_run(w, 0, 1'b1);
      checks++;
      if (r_done_after_last != 1 || r_done_early != 0 || r_ready_low != 0
          || a_pass !== want_pass || a_err !== want_err) begin
        errors++;
        $display("FAIL random_%0d: done=%0d early=%0d pass=%b err=%h want 1 0 %b %h",
                 r, r_done_after_last, r_done_early, a_pass, a_err, want_pass, want_err);
      end
      cycle();
      $display("random run %0d: pass=%b err_idx=%h", r, a_pass, a_err);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_stall();
    test_len20();
    test_abort();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
